// File: rtl/tcdm_rr_arb_tree_if.sv
// Bus bundle for one TCDM bank arbiter: the requester side (req/gnt/data per
// master) and the downstream side (single req/gnt with the selected payload).
interface tcdm_rr_arb_tree_if #(
    parameter int unsigned NumReq    = 8,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]                req_i;
    logic [NumReq-1:0]                gnt_o;
    logic [NumReq-1:0][DataWidth-1:0] data_i;
    logic                             gnt_i;
    logic                             req_o;
    logic [DataWidth-1:0]             data_o;
    logic [IdxWidth-1:0]              idx_o;

    // Arbiter side
    modport slave (
        input  req_i, data_i, gnt_i,
        output gnt_o, req_o, data_o, idx_o
    );

    // Driver side (decoders upstream, bank downstream)
    modport master (
        output req_i, data_i, gnt_i,
        input  gnt_o, req_o, data_o, idx_o
    );
endinterface

// File: rtl/tcdm_rr_arb_tree.sv
// Round-robin arbiter for one TCDM bank. Selection is combinational; the only
// state is the round-robin pointer, which moves one past the winner on every
// downstream handshake.
module tcdm_rr_arb_tree #(
    parameter int unsigned NumReq    = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tcdm_rr_arb_tree_if.slave     bus
);
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxWidth-1:0]  rr_q, rr_d, idx;
    logic                 req_any, hs;
    logic [NumReq-1:0]    gnt;
    logic [DataWidth-1:0] data;

    // Any requester active
    always_comb req_any = |bus.req_i;

    // Masked priority encoder with fallback: lowest requester at or above the
    // pointer wins; if none, lowest requester overall (the wrapped search).
    always_comb begin
        idx = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--)
            if (bus.req_i[i]) idx = IdxWidth'(i);
        for (int i = int'(NumReq) - 1; i >= 0; i--)
            if (bus.req_i[i] && (IdxWidth'(i) >= rr_q)) idx = IdxWidth'(i);
    end

    // Payload mux and grant decode; only the winner's data is ever read, so
    // unused lanes cannot leak into data_o and idle output is zero.
    always_comb begin
        data = '0;
        gnt  = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (req_any && (idx == IdxWidth'(i))) begin
                data   = bus.data_i[i];
                gnt[i] = bus.gnt_i;
            end
        end
    end

    // Next pointer: one past the winner on handshake, wrapping at NumReq-1
    always_comb begin
        hs   = req_any & bus.gnt_i;
        rr_d = rr_q;
        if (hs)
            rr_d = (idx == IdxWidth'(NumReq - 1)) ? '0 : idx + IdxWidth'(1);
    end

    generate
        if (NumReq > 1) begin : g_rr
            // Pointer register; reset takes priority over a same-cycle handshake
            always_ff @(posedge clk_i) begin
                if (rst_i) rr_q <= '0;
                else       rr_q <= rr_d;
            end
        end else begin : g_single
            assign rr_q = '0;
        end
    endgenerate

    assign bus.req_o  = req_any;
    assign bus.gnt_o  = gnt;
    assign bus.data_o = data;
    assign bus.idx_o  = idx;
endmodule

// File: tb/tb_tcdm_rr_arb_tree.sv
// Directed bench for tcdm_rr_arb_tree: a 4-requester instance for the main
// scenarios and a 5-requester instance for the non-power-of-two wrap.
module tb_tcdm_rr_arb_tree;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tcdm_rr_arb_tree_if #(.NumReq(4), .DataWidth(8)) ia ();
    tcdm_rr_arb_tree_if #(.NumReq(5), .DataWidth(8)) ib ();

    tcdm_rr_arb_tree #(.NumReq(4), .DataWidth(8)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (ia)
    );

    tcdm_rr_arb_tree #(.NumReq(5), .DataWidth(8)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (ib)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, check combinational outputs, then clock once
    task automatic step_a(input string tag, input logic [3:0] rq, input logic g,
                          input logic er, input logic [3:0] eg,
                          input logic [1:0] ei, input logic [7:0] ed);
        ia.req_i = rq;
        ia.gnt_i = g;
        #1;
        chk({tag, ".req"},  32'(ia.req_o),  32'(er));
        chk({tag, ".gnt"},  32'(ia.gnt_o),  32'(eg));
        chk({tag, ".idx"},  32'(ia.idx_o),  32'(ei));
        chk({tag, ".data"}, 32'(ia.data_o), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string tag, input logic [4:0] rq, input logic g,
                          input logic [4:0] eg, input logic [2:0] ei,
                          input logic [7:0] ed);
        ib.req_i = rq;
        ib.gnt_i = g;
        #1;
        chk({tag, ".gnt"},  32'(ib.gnt_o),  32'(eg));
        chk({tag, ".idx"},  32'(ib.idx_o),  32'(ei));
        chk({tag, ".data"}, 32'(ib.data_o), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        ia.req_i  = '0;
        ia.gnt_i  = 1'b1;
        ia.data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ib.req_i  = '0;
        ib.gnt_i  = 1'b1;
        ib.data_i = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state: idle outputs
        step_a("rst", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);

        // 1. All requesting, full rotation
        step_a("rr0", 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0);
        step_a("rr1", 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
        step_a("rr2", 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
        step_a("rr3", 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);
        step_a("rr4", 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0);

        // 2. Idle keeps pointer (at 1); then single requester 2, pointer -> 3
        step_a("idle0", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);
        step_a("idle1", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);
        step_a("idle2", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);
        step_a("one2",  4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
        step_a("ptr3",  4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);

        // 3. Backpressure after reset
        rst_a = 1'b1;
        step_a("rst2", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00);
        rst_a = 1'b0;
        step_a("bp0", 4'b1010, 1'b0, 1'b1, 4'b0000, 2'd1, 8'hA1);
        step_a("bp1", 4'b1010, 1'b0, 1'b1, 4'b0000, 2'd1, 8'hA1);
        ia.data_i[3] = 8'h55; // unselected lane must not disturb data_o
        step_a("bp2", 4'b1010, 1'b0, 1'b1, 4'b0000, 2'd1, 8'hA1);
        ia.data_i[3] = 8'hA3;
        step_a("bpg", 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
        step_a("bpn", 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);

        // 4. Wrap: pointer now 0
        step_a("wr0", 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0);
        step_a("wr1", 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);
        step_a("wr2", 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0);

        // 5. Pointer 1 -> grant 1 -> pointer 2; reset in the same cycle as a handshake
        step_a("pre", 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
        rst_a = 1'b1;
        step_a("mrst", 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
        rst_a = 1'b0;
        step_a("post", 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0);

        // 6. Five requesters, ends only
        step_b("n5a", 5'b10001, 1'b1, 5'b00001, 3'd0, 8'hA0);
        step_b("n5b", 5'b10001, 1'b1, 5'b10000, 3'd4, 8'hA4);
        step_b("n5c", 5'b10001, 1'b1, 5'b00001, 3'd0, 8'hA0);
        step_b("n5d", 5'b10001, 1'b1, 5'b10000, 3'd4, 8'hA4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
